// File: rtl/qq_pkg.sv
// qq_pkg: shared types and constants for the quick-queue scheduler and node logic.
package qq_pkg;

  typedef enum logic {
    OP_ENQ = 1'b0,
    OP_DEQ = 1'b1
  } qq_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } qq_sched_state_t;

  // Largest representable key; node logic uses it as the "empty slot" sentinel.
  localparam logic [31:0] MAX_KEY = 32'hFFFF_FFFF;

  // A request may issue only if the chain can absorb it right now.
  function automatic logic op_elig(qq_op_t op, logic full, logic empty);
    return (op == OP_DEQ) ? !empty : !full;
  endfunction

endpackage

// File: rtl/qq_sched_if.sv
// qq_sched_if: requester-side and chain-side signals of the scheduler.
// slave = the scheduler, master = clients plus head node.
interface qq_sched_if #(
  parameter int W = 32,
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_key;
  logic [N-1:0]   req_ack;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_key;
  logic           q_enq;
  logic           q_deq;
  logic [W-1:0]   q_key;
  logic           q_rdy;
  logic           q_full;
  logic           q_empty;
  logic [W-1:0]   q_min;

  modport slave (
    input  req_valid, req_op, req_key, q_rdy, q_full, q_empty, q_min,
    output req_ack, rsp_valid, rsp_id, rsp_key, q_enq, q_deq, q_key
  );

  modport master (
    output req_valid, req_op, req_key, q_rdy, q_full, q_empty, q_min,
    input  req_ack, rsp_valid, rsp_id, rsp_key, q_enq, q_deq, q_key
  );

endinterface

// File: rtl/qq_sched_rr_arb.sv
// rr_arb: combinational round-robin pick; the search starts at rr_i and wraps.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] rr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // First eligible index at or after rr_i, modulo N.
  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    any_o = |elig_i;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(rr_i) + k) % N;
      if (!found && elig_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/qq_sched.sv
// qq_sched: round-robin front end that serialises N requesters onto one
// quick-queue chain. Optional QQ_SCHED_DEQ_FIRST_EN: dequeues beat enqueues.
module qq_sched
  import qq_pkg::*;
#(
  parameter int W   = 32,
  parameter int N   = 4,
  parameter int CAP = 16,
  parameter int IW  = $clog2(N),
  parameter int OW  = $clog2(CAP + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  qq_sched_if.slave      bus,
  output logic [OW-1:0]  occ_o
);

  qq_sched_state_t state_q;
  logic [IW-1:0]   rr_q;
  logic [OW-1:0]   occ_q, occ_d;
  logic [N-1:0]    ack_q;
  logic            enq_q, deq_q, rsp_vld_q;
  logic [W-1:0]    qkey_q, rsp_key_q;
  logic [IW-1:0]   rsp_id_q;

  logic [N-1:0]    elig;
  logic [N-1:0]    win_gnt;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  qq_op_t          win_op;
  logic            issue;

  // Per-requester eligibility against the chain status.
  for (genvar i = 0; i < N; i++) begin : g_elig
    assign elig[i] = bus.req_valid[i] &
                     op_elig(qq_op_t'(bus.req_op[i]), bus.q_full, bus.q_empty);
  end

`ifdef QQ_SCHED_DEQ_FIRST_EN
  logic [N-1:0]  deq_gnt, enq_gnt;
  logic [IW-1:0] deq_idx, enq_idx;
  logic          deq_any, enq_any;

  rr_arb #(.N(N), .IW(IW)) u_arb_deq (
    .elig_i(elig & bus.req_op), .rr_i(rr_q),
    .gnt_o(deq_gnt), .idx_o(deq_idx), .any_o(deq_any)
  );
  rr_arb #(.N(N), .IW(IW)) u_arb_enq (
    .elig_i(elig & ~bus.req_op), .rr_i(rr_q),
    .gnt_o(enq_gnt), .idx_o(enq_idx), .any_o(enq_any)
  );

  assign win_gnt = deq_any ? deq_gnt : enq_gnt;
  assign win_idx = deq_any ? deq_idx : enq_idx;
  assign win_any = deq_any | enq_any;
`else
  rr_arb #(.N(N), .IW(IW)) u_arb (
    .elig_i(elig), .rr_i(rr_q),
    .gnt_o(win_gnt), .idx_o(win_idx), .any_o(win_any)
  );
`endif

  assign win_op = qq_op_t'(bus.req_op[win_idx]);
  assign issue  = (state_q == IDLE) && bus.q_rdy && win_any;

  // Occupancy next value; saturation is only a guard, eligibility prevents wrap.
  always_comb begin
    occ_d = occ_q;
    if (issue) begin
      if (win_op == OP_DEQ) begin
        if (occ_q != '0) occ_d = occ_q - OW'(1);
      end else begin
        if (occ_q != OW'(CAP)) occ_d = occ_q + OW'(1);
      end
    end
  end

  // Scheduler FSM with registered pulse outputs. BUSY lasts exactly one cycle
  // to skip the stale q_rdy; waiting for a fresh q_rdy happens in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      occ_q     <= '0;
      ack_q     <= '0;
      enq_q     <= 1'b0;
      deq_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      qkey_q    <= '0;
      rsp_key_q <= '0;
      rsp_id_q  <= '0;
    end else begin
      ack_q     <= '0;
      enq_q     <= 1'b0;
      deq_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            ack_q   <= win_gnt;
            enq_q   <= (win_op == OP_ENQ);
            deq_q   <= (win_op == OP_DEQ);
            qkey_q  <= bus.req_key[int'(win_idx)*W +: W];
            occ_q   <= occ_d;
            rr_q    <= (win_idx == IW'(N-1)) ? '0 : win_idx + IW'(1);
            state_q <= BUSY;
            if (win_op == OP_DEQ) begin
              rsp_vld_q <= 1'b1;
              rsp_key_q <= bus.q_min;
              rsp_id_q  <= win_idx;
            end
          end
        end
        BUSY:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.q_enq     = enq_q;
  assign bus.q_deq     = deq_q;
  assign bus.q_key     = qkey_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_key   = rsp_key_q;
  assign bus.rsp_id    = rsp_id_q;
  assign occ_o         = occ_q;

endmodule

// File: tb/tb_qq_sched.sv
// tb_qq_sched: directed vectors for qq_sched with hand-computed expectations.
module tb_qq_sched;
  import qq_pkg::*;

  localparam int W = 32, N = 4, CAP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] occ;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  qq_sched_if #(.W(W), .N(N)) bus ();

  qq_sched #(.W(W), .N(N), .CAP(CAP)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave),
    .occ_o (occ)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic op, input logic [W-1:0] key);
    bus.req_valid[i]     = v;
    bus.req_op[i]        = op;
    bus.req_key[i*W +: W] = key;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".ack"}, bus.req_ack, 4'b0000);
    chk({tag, ".enq"}, bus.q_enq, 1'b0);
    chk({tag, ".deq"}, bus.q_deq, 1'b0);
    chk({tag, ".rspv"}, bus.rsp_valid, 1'b0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_key   = '0;
    bus.q_rdy     = 1'b0;
    bus.q_full    = 1'b0;
    bus.q_empty   = 1'b1;
    bus.q_min     = '0;

    // Reset values
    tick();
    chk_idle_outs("rst");
    chk("rst.qkey", bus.q_key, 32'h0);
    chk("rst.rkey", bus.rsp_key, 32'h0);
    chk("rst.rid", bus.rsp_id, 2'd0);
    chk("rst.occ", occ, 5'd0);
    rst_n = 1'b1;

    // Single enqueue; held off while q_rdy is low
    set_req(0, 1'b1, 1'b0, 32'h10);
    tick(); tick();
    chk("nordy.ack", bus.req_ack, 4'b0000);
    bus.q_rdy = 1'b1;
    tick();
    chk("enq1.ack", bus.req_ack, 4'b0001);
    chk("enq1.qenq", bus.q_enq, 1'b1);
    chk("enq1.qdeq", bus.q_deq, 1'b0);
    chk("enq1.qkey", bus.q_key, 32'h10);
    chk("enq1.occ", occ, 5'd1);
    set_req(0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("enq1.stale", bus.req_ack, 4'b0000);

    // Four simultaneous enqueues: granted 0..3, one every two cycles
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'h20 + i);
    for (int i = 0; i < N; i++) begin
      tick();
      chk($sformatf("rr%0d.ack", i), bus.req_ack, 4'b0001 << i);
      chk($sformatf("rr%0d.key", i), bus.q_key, 32'h20 + i);
      set_req(i, 1'b0, 1'b0, 32'h0);
      tick();
      chk($sformatf("rr%0d.gap", i), bus.req_ack, 4'b0000);
    end
    chk("rr.occ", occ, 5'd4);

    // Dequeue held while chain empty, then served with q_min
    bus.q_empty = 1'b1;
    set_req(2, 1'b1, 1'b1, 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("empty%0d.ack", c), bus.req_ack, 4'b0000);
    end
    bus.q_empty = 1'b0;
    bus.q_min   = 32'h07;
    tick();
    chk("deq.ack", bus.req_ack, 4'b0100);
    chk("deq.qdeq", bus.q_deq, 1'b1);
    chk("deq.qenq", bus.q_enq, 1'b0);
    chk("deq.rspv", bus.rsp_valid, 1'b1);
    chk("deq.rid", bus.rsp_id, 2'd2);
    chk("deq.rkey", bus.rsp_key, 32'h07);
    chk("deq.occ", occ, 5'd3);
    set_req(2, 1'b0, 1'b0, 32'h0);
    tick();
    chk("deq.rsp1cy", bus.rsp_valid, 1'b0);

    // Chain full: deq3 goes first, enq1 waits for q_full to drop
    do_reset();
    bus.q_full  = 1'b1;
    bus.q_empty = 1'b0;
    bus.q_min   = 32'h99;
    set_req(1, 1'b1, 1'b0, 32'h55);
    set_req(3, 1'b1, 1'b1, 32'h0);
    tick();
    chk("full.ack3", bus.req_ack, 4'b1000);
    chk("full.rid", bus.rsp_id, 2'd3);
    chk("full.rkey", bus.rsp_key, 32'h99);
    chk("full.occsat", occ, 5'd0);
    set_req(3, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("full%0d.hold", c), bus.req_ack, 4'b0000);
    end
    bus.q_full = 1'b0;
    tick();
    chk("full.ack1", bus.req_ack, 4'b0010);
    chk("full.qenq", bus.q_enq, 1'b1);
    chk("full.qkey", bus.q_key, 32'h55);
    chk("full.occ", occ, 5'd1);
    set_req(1, 1'b0, 1'b0, 32'h0);
    tick();

    // enq0 vs deq1 with rr=0: class priority depends on build option
    do_reset();
    bus.q_min = 32'h33;
    set_req(0, 1'b1, 1'b0, 32'h0A);
    set_req(1, 1'b1, 1'b1, 32'h0);
    tick();
`ifdef QQ_SCHED_DEQ_FIRST_EN
    chk("mix.first", bus.req_ack, 4'b0010);
    chk("mix.rkey", bus.rsp_key, 32'h33);
    set_req(1, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("mix.second", bus.req_ack, 4'b0001);
    set_req(0, 1'b0, 1'b0, 32'h0);
`else
    chk("mix.first", bus.req_ack, 4'b0001);
    chk("mix.qkey", bus.q_key, 32'h0A);
    set_req(0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("mix.second", bus.req_ack, 4'b0010);
    chk("mix.rid", bus.rsp_id, 2'd1);
    set_req(1, 1'b0, 1'b0, 32'h0);
`endif
    tick();

    // Reset while BUSY
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'hAB);
    tick();
    chk("busy.ack", bus.req_ack, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk_idle_outs("midrst");
    chk("midrst.qkey", bus.q_key, 32'h0);
    chk("midrst.occ", occ, 5'd0);
    set_req(1, 1'b1, 1'b0, 32'hCD);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst.ack", bus.req_ack, 4'b0001);
    chk("postrst.qkey", bus.q_key, 32'hAB);
    chk("postrst.occ", occ, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qq_sched.md
# qq_sched

Front-end scheduler that shares one quick-queue chain between N requesters. Each requester posts an enqueue or dequeue; the block round-robin arbitrates among eligible requests, issues at most one operation to the head node when the chain reports ready, and returns dequeued keys tagged with the requester ID. It sits between client logic and the first `qq_node` of the chain, and owns all `enq_i`/`deq_i` sequencing for that chain.

## Interface
- `W`, 32, key width
- `N`, 4, number of requesters (≥2)
- `CAP`, 16, total chain capacity in entries (occupancy counter range)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  N  request pending, per requester
- `req_op`  in  N  per requester: 0 = enqueue, 1 = dequeue
- `req_key`  in  N*W  enqueue key, requester i at bits [i*W +: W]
- `req_ack`  out  N  one-hot one-cycle pulse: request i accepted
- `rsp_valid`  out  1  dequeue response valid (one cycle)
- `rsp_id`  out  $clog2(N)  requester receiving the response
- `rsp_key`  out  W  dequeued key
- `q_enq`, `q_deq`  out  1  one-cycle operation pulses to head node
- `q_key`  out  W  enqueue key to head node
- `q_rdy`, `q_full`, `q_empty`  in  1  head-node status
- `q_min`  in  W  head-node minimum key (valid when `q_rdy` & !`q_empty`)
- `occ`  out  $clog2(CAP+1)  entries currently held

## Operation
- States: IDLE, BUSY.
- Eligibility: request i eligible iff `req_valid[i]` and (op=enq and !`q_full`) or (op=deq and !`q_empty`). Ineligible requests are held, never acked, never dropped.
- IDLE: if `q_rdy` and ≥1 eligible, pick winner by round-robin starting at pointer `rr`; register `req_ack[win]`, `q_enq`/`q_deq`, `q_key=req_key[win]`; go BUSY. For deq, capture `q_min` and `win` in the same edge → `rsp_valid`, `rsp_key`, `rsp_id`. `rr` ← win+1 mod N.
- BUSY: first cycle after issue ignores `q_rdy` (stale); from the second cycle on, return to IDLE when `q_rdy`=1.
- `occ`: +1 on each issued enq, −1 on each issued deq; never wraps (eligibility guarantees it; saturate as safety).
- Requester must hold `req_valid`/`req_op`/`req_key` stable until its `req_ack`; may change them the cycle after ack.
- No eligible requests: stay IDLE, all pulse outputs 0, `rr` unchanged.

## Timing
- Reset: state IDLE, `rr`=0, `occ`=0; `req_ack`, `q_enq`, `q_deq`, `rsp_valid` = 0; `q_key`, `rsp_key` = 0; `rsp_id`=0.
- Latency: eligible request sampled at edge t (in IDLE, `q_rdy`=1) → `req_ack`, `q_*` pulse, and for deq `rsp_*`, during cycle t+1.
- Max issue rate: one op per 2 cycles (issue + stale cycle); lower when chain holds `q_rdy` low.
- All outputs registered; no combinational path from `q_*` inputs to outputs.
- Reset asserted mid-BUSY: return to reset values immediately; in-flight chain op is the chain's concern, `occ` restarts at 0 (chain is reset together).
- Simultaneous enq and deq from different requesters: only the RR winner issues; other waits ≥2 cycles.

## Configuration
- `QQ_SCHED_DEQ_FIRST_EN` defined: any eligible dequeue beats all eligible enqueues; round-robin applies within the winning class, single shared `rr`.
- Undefined: pure round-robin over all eligible requests regardless of op.

## Structure
- Package `qq_pkg`: `qq_op_t` (OP_ENQ=0, OP_DEQ=1), `qq_sched_state_t` (IDLE, BUSY), `MAX_KEY` constant shared with node logic.
- Sub-module `rr_arb` (parameter N): inputs eligible mask and `rr`, outputs one-hot grant and index, purely combinational; instantiated once (twice when `QQ_SCHED_DEQ_FIRST_EN`, deq mask and enq mask).

## Test plan
- Reset, N=4, req0 enq 0x10 with `q_rdy`=1 → cycle after: `req_ack`=0001, `q_enq`=1, `q_key`=0x10, `occ`=1.
- All four req enq simultaneously, `q_rdy` always 1 → acks in order 0,1,2,3, one per 2 cycles; `occ`=4.
- req2 deq with `q_empty`=1 for 5 cycles → no ack; `q_empty`→0, `q_min`=0x07 → `rsp_valid`, `rsp_id`=2, `rsp_key`=0x07, `q_deq` pulse.
- `q_full`=1, req1 enq and req3 deq pending, `rr`=0 → req3 acked first; req1 acked only after `q_full` drops.
- req0 enq and req1 deq, `rr`=0: without macro req0 first; with `QQ_SCHED_DEQ_FIRST_EN` req1 first.
- `rst` low during BUSY → next cycle all outputs at reset values, `occ`=0, state IDLE.
